// File: rtl/xadac_pkg.sv
// Shared types for the XADAC request router: scoreboard depth, id and payload layouts.
package xadac_pkg;

  localparam int unsigned SbLen = 8;
  localparam int unsigned IdW   = $clog2(SbLen);

  typedef logic [31:0]    InstrT;
  typedef logic [IdW-1:0] IdT;

  typedef struct packed {
    IdT    id;
    InstrT instr;
  } DecReqT;

  typedef struct packed {
    IdT         id;
    logic       accept;
    logic       rd_we;
    logic [1:0] rs_used;
  } DecRspT;

  typedef struct packed {
    IdT          id;
    InstrT       instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ExeReqT;

  typedef struct packed {
    IdT          id;
    logic [31:0] rd;
    logic        err;
  } ExeRspT;

  localparam int unsigned DecReqW = $bits(DecReqT);
  localparam int unsigned DecRspW = $bits(DecRspT);
  localparam int unsigned ExeReqW = $bits(ExeReqT);
  localparam int unsigned ExeRspW = $bits(ExeRspT);

  function automatic logic hits(InstrT instr, InstrT mask, InstrT match);
    return (instr & mask) == match;
  endfunction

endpackage

// File: rtl/xadac_rr_arb.sv
// N-input round-robin arbiter; once an offer stalls, the grant stays locked until it is taken.
module xadac_rr_arb #(
  parameter int unsigned N = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, pick, sel;
  logic [IdxW:0]   cand;
  logic            lock_q, lock_d, found, hs;

  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // cand spans up to 2N-2, hence the extra bit before wrapping
      cand = {1'b0, ptr_q} + (IdxW + 1)'(k);
      if (cand >= (IdxW + 1)'(N)) cand = cand - (IdxW + 1)'(N);
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IdxW-1:0];
      end
    end

    if (lock_q) begin
      sel     = lock_idx_q;
      valid_o = req_i[lock_idx_q];
    end else begin
      sel     = pick;
      valid_o = found;
    end

    gnt_o = '0;
    if (valid_o) gnt_o[sel] = 1'b1;
    idx_o = sel;
    hs    = valid_o & ready_i;

    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    if (hs) begin
      lock_d = 1'b0;
      ptr_d  = (sel == IdxW'(N - 1)) ? '0 : sel + 1'b1;
    end else if (valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/xadac_router.sv
// XADAC router: one slave port to NoMst accelerators plus a local reject responder (source NoMst).
module xadac_router
  import xadac_pkg::*;
#(
  parameter int unsigned       NoMst = 4,
  parameter InstrT [NoMst-1:0] Mask  = '0,
  parameter InstrT [NoMst-1:0] Match = '0
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            slv_dec_req_valid_i,
  input  logic [DecReqW-1:0]              slv_dec_req_i,
  output logic                            slv_dec_req_ready_o,
  output logic                            slv_dec_rsp_valid_o,
  output logic [DecRspW-1:0]              slv_dec_rsp_o,
  input  logic                            slv_dec_rsp_ready_i,
  input  logic                            slv_exe_req_valid_i,
  input  logic [ExeReqW-1:0]              slv_exe_req_i,
  output logic                            slv_exe_req_ready_o,
  output logic                            slv_exe_rsp_valid_o,
  output logic [ExeRspW-1:0]              slv_exe_rsp_o,
  input  logic                            slv_exe_rsp_ready_i,
  output logic [NoMst-1:0]                mst_dec_req_valid_o,
  output logic [NoMst-1:0][DecReqW-1:0]   mst_dec_req_o,
  input  logic [NoMst-1:0]                mst_dec_req_ready_i,
  input  logic [NoMst-1:0]                mst_dec_rsp_valid_i,
  input  logic [NoMst-1:0][DecRspW-1:0]   mst_dec_rsp_i,
  output logic [NoMst-1:0]                mst_dec_rsp_ready_o,
  output logic [NoMst-1:0]                mst_exe_req_valid_o,
  output logic [NoMst-1:0][ExeReqW-1:0]   mst_exe_req_o,
  input  logic [NoMst-1:0]                mst_exe_req_ready_i,
  input  logic [NoMst-1:0]                mst_exe_rsp_valid_i,
  input  logic [NoMst-1:0][ExeRspW-1:0]   mst_exe_rsp_i,
  output logic [NoMst-1:0]                mst_exe_rsp_ready_o,
  output logic [NoMst:0]                  pending
);

  localparam int unsigned     NoSrc = NoMst + 1;
  localparam int unsigned     SrcW  = $clog2(NoSrc);
  localparam logic [SrcW-1:0] Loc   = SrcW'(NoMst);

  DecReqT dec_req;
  ExeReqT exe_req;
  assign dec_req = DecReqT'(slv_dec_req_i);
  assign exe_req = ExeReqT'(slv_exe_req_i);

  logic [SbLen-1:0]           sb_valid_q, sb_valid_d;
  logic [SbLen-1:0][SrcW-1:0] sb_tgt_q, sb_tgt_d;
  logic                       loc_dec_full_q, loc_dec_full_d, loc_exe_full_q, loc_exe_full_d;
  IdT                         loc_dec_id_q, loc_dec_id_d, loc_exe_id_q, loc_exe_id_d;

  logic [SrcW-1:0]  dec_tgt, exe_tgt;
  logic             dec_free, dec_hs, exe_hs;
  logic [NoSrc-1:0] dec_src_ready, exe_src_ready, dec_fwd, exe_fwd;

  // Outputs are qualified with rstn so every valid/ready drops the moment reset asserts.
  always_comb begin : dec_route
    dec_tgt = Loc;
    for (int i = NoMst - 1; i >= 0; i--) begin
      if (hits(dec_req.instr, Mask[i], Match[i])) dec_tgt = SrcW'(i);
    end
    dec_free            = ~sb_valid_q[dec_req.id];
    dec_src_ready       = {~loc_dec_full_q, mst_dec_req_ready_i};
    slv_dec_req_ready_o = rstn & dec_free & dec_src_ready[dec_tgt];
    dec_fwd             = '0;
    dec_fwd[dec_tgt]    = rstn & slv_dec_req_valid_i & dec_free;
    dec_hs              = slv_dec_req_valid_i & slv_dec_req_ready_o;
  end

  // A same-cycle decode allocation of this id wins over the registered entry.
  always_comb begin : exe_route
    exe_tgt = sb_valid_q[exe_req.id] ? sb_tgt_q[exe_req.id] : Loc;
    if (dec_hs && (dec_req.id == exe_req.id)) exe_tgt = dec_tgt;
    exe_src_ready       = {~loc_exe_full_q, mst_exe_req_ready_i};
    slv_exe_req_ready_o = rstn & exe_src_ready[exe_tgt];
    exe_fwd             = '0;
    exe_fwd[exe_tgt]    = rstn & slv_exe_req_valid_i;
    exe_hs              = slv_exe_req_valid_i & slv_exe_req_ready_o;
  end

  assign mst_dec_req_valid_o = dec_fwd[NoMst-1:0];
  assign mst_dec_req_o       = {NoMst{slv_dec_req_i}};
  assign mst_exe_req_valid_o = exe_fwd[NoMst-1:0];
  assign mst_exe_req_o       = {NoMst{slv_exe_req_i}};

  logic [NoSrc-1:0]   dec_rsp_req, exe_rsp_req, dec_gnt, exe_gnt;
  logic [SrcW-1:0]    dec_idx, exe_idx;
  logic               dec_arb_valid, exe_arb_valid, dec_rsp_hs, exe_rsp_hs;
  DecRspT [NoSrc-1:0] dec_src_rsp;
  ExeRspT [NoSrc-1:0] exe_src_rsp;
  DecRspT             dec_rsp;
  ExeRspT             exe_rsp;

  assign dec_rsp_req = {loc_dec_full_q, mst_dec_rsp_valid_i};
  assign exe_rsp_req = {loc_exe_full_q, mst_exe_rsp_valid_i};

  xadac_rr_arb #(.N(NoSrc)) i_dec_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (dec_rsp_req),
    .ready_i (slv_dec_rsp_ready_i),
    .valid_o (dec_arb_valid),
    .gnt_o   (dec_gnt),
    .idx_o   (dec_idx)
  );

  xadac_rr_arb #(.N(NoSrc)) i_exe_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (exe_rsp_req),
    .ready_i (slv_exe_rsp_ready_i),
    .valid_o (exe_arb_valid),
    .gnt_o   (exe_gnt),
    .idx_o   (exe_idx)
  );

  // The local responder rejects: only the id is echoed, every other field is zero.
  always_comb begin : rsp_mux
    for (int unsigned i = 0; i < NoMst; i++) begin
      dec_src_rsp[i] = DecRspT'(mst_dec_rsp_i[i]);
      exe_src_rsp[i] = ExeRspT'(mst_exe_rsp_i[i]);
    end
    dec_src_rsp[NoMst]    = '0;
    dec_src_rsp[NoMst].id = loc_dec_id_q;
    exe_src_rsp[NoMst]    = '0;
    exe_src_rsp[NoMst].id = loc_exe_id_q;
    dec_rsp = dec_src_rsp[dec_idx];
    exe_rsp = exe_src_rsp[exe_idx];
  end

  assign slv_dec_rsp_valid_o = rstn & dec_arb_valid;
  assign slv_dec_rsp_o       = dec_rsp;
  assign mst_dec_rsp_ready_o = dec_gnt[NoMst-1:0] & {NoMst{rstn & slv_dec_rsp_ready_i}};
  assign dec_rsp_hs          = slv_dec_rsp_valid_o & slv_dec_rsp_ready_i;
  assign slv_exe_rsp_valid_o = rstn & exe_arb_valid;
  assign slv_exe_rsp_o       = exe_rsp;
  assign mst_exe_rsp_ready_o = exe_gnt[NoMst-1:0] & {NoMst{rstn & slv_exe_rsp_ready_i}};
  assign exe_rsp_hs          = slv_exe_rsp_valid_o & slv_exe_rsp_ready_i;

  always_comb begin : state_next
    sb_valid_d     = sb_valid_q;
    sb_tgt_d       = sb_tgt_q;
    loc_dec_full_d = loc_dec_full_q;
    loc_dec_id_d   = loc_dec_id_q;
    loc_exe_full_d = loc_exe_full_q;
    loc_exe_id_d   = loc_exe_id_q;

    if (dec_rsp_hs && dec_gnt[Loc]) begin
      loc_dec_full_d = 1'b0;
      // Leave the entry alone if the id was already freed and reallocated to a master.
      if (sb_tgt_q[dec_rsp.id] == Loc) sb_valid_d[dec_rsp.id] = 1'b0;
    end
    if (exe_rsp_hs) begin
      sb_valid_d[exe_rsp.id] = 1'b0;
      if (exe_gnt[Loc]) loc_exe_full_d = 1'b0;
    end
    // Allocation needs a free entry, so it never collides with a same-cycle free of that id.
    if (dec_hs) begin
      sb_valid_d[dec_req.id] = 1'b1;
      sb_tgt_d[dec_req.id]   = dec_tgt;
      if (dec_tgt == Loc) begin
        loc_dec_full_d = 1'b1;
        loc_dec_id_d   = dec_req.id;
      end
    end
    if (exe_hs && (exe_tgt == Loc)) begin
      loc_exe_full_d = 1'b1;
      loc_exe_id_d   = exe_req.id;
    end
  end

  always_comb begin : pending_map
    pending = '0;
    for (int unsigned e = 0; e < SbLen; e++) begin
      if (sb_valid_q[e]) pending[sb_tgt_q[e]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_valid_q     <= '0;
      sb_tgt_q       <= '0;
      loc_dec_full_q <= 1'b0;
      loc_dec_id_q   <= '0;
      loc_exe_full_q <= 1'b0;
      loc_exe_id_q   <= '0;
    end else begin
      sb_valid_q     <= sb_valid_d;
      sb_tgt_q       <= sb_tgt_d;
      loc_dec_full_q <= loc_dec_full_d;
      loc_dec_id_q   <= loc_dec_id_d;
      loc_exe_full_q <= loc_exe_full_d;
      loc_exe_id_q   <= loc_exe_id_d;
    end
  end

endmodule

// File: tb/tb_xadac_router.sv
// Bench for xadac_router (two masters): directed scenarios plus random traffic vs. a queue model.
module tb_xadac_router;
  import xadac_pkg::*;

  localparam int          Loc    = 2;
  localparam InstrT [1:0] MaskP  = {32'h0000_007F, 32'h0000_007F};
  localparam InstrT [1:0] MatchP = {32'h0000_002B, 32'h0000_000B};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic   dq_v, dq_r, ds_v, ds_r, eq_v, eq_r, es_v, es_r;
  DecReqT dq;
  DecRspT ds;
  ExeReqT eq;
  ExeRspT es;
  logic [1:0]              m_dq_v, m_dq_r, m_ds_v, m_ds_r, m_eq_v, m_eq_r, m_es_v, m_es_r;
  logic [1:0][DecReqW-1:0] m_dq;
  logic [1:0][DecRspW-1:0] m_ds;
  logic [1:0][ExeReqW-1:0] m_eq;
  logic [1:0][ExeRspW-1:0] m_es;
  logic [2:0]              pend;

  xadac_router #(.NoMst(2), .Mask(MaskP), .Match(MatchP)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .slv_dec_req_valid_i (dq_v),
    .slv_dec_req_i       (dq),
    .slv_dec_req_ready_o (dq_r),
    .slv_dec_rsp_valid_o (ds_v),
    .slv_dec_rsp_o       (ds),
    .slv_dec_rsp_ready_i (ds_r),
    .slv_exe_req_valid_i (eq_v),
    .slv_exe_req_i       (eq),
    .slv_exe_req_ready_o (eq_r),
    .slv_exe_rsp_valid_o (es_v),
    .slv_exe_rsp_o       (es),
    .slv_exe_rsp_ready_i (es_r),
    .mst_dec_req_valid_o (m_dq_v),
    .mst_dec_req_o       (m_dq),
    .mst_dec_req_ready_i (m_dq_r),
    .mst_dec_rsp_valid_i (m_ds_v),
    .mst_dec_rsp_i       (m_ds),
    .mst_dec_rsp_ready_o (m_ds_r),
    .mst_exe_req_valid_o (m_eq_v),
    .mst_exe_req_o       (m_eq),
    .mst_exe_req_ready_i (m_eq_r),
    .mst_exe_rsp_valid_i (m_es_v),
    .mst_exe_rsp_i       (m_es),
    .mst_exe_rsp_ready_o (m_es_r),
    .pending             (pend)
  );

  // Reference model: scoreboard as arrays, local responder buffers as queues, arbiters as ints.
  bit sb_busy [SbLen];
  int sb_who  [SbLen];
  int ldq[$];
  int leq[$];
  int dptr, eptr, dlk, elk;
  bit dlock, elock;
  int n_err = 0;
  int n_chk = 0;
  DecRspT dr;
  ExeRspT xr;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SbLen; i++) begin
      sb_busy[i] = 1'b0;
      sb_who[i]  = 0;
    end
    ldq.delete();
    leq.delete();
    dptr = 0; eptr = 0; dlk = 0; elk = 0; dlock = 1'b0; elock = 1'b0;
  endtask

  function automatic int route(InstrT instr);
    for (int i = 0; i < 2; i++) if ((instr & MaskP[i]) == MatchP[i]) return i;
    return Loc;
  endfunction

  function automatic int pick(logic [2:0] req, int ptr, bit lock, int lk);
    if (lock) return req[lk] ? lk : -1;
    for (int k = 0; k < 3; k++) if (req[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  task automatic idle();
    dq_v = 1'b0; dq = '0; eq_v = 1'b0; eq = '0; ds_r = 1'b0; es_r = 1'b0;
    m_dq_r = 2'b11; m_eq_r = 2'b11; m_ds_v = '0; m_ds = '0; m_es_v = '0; m_es = '0;
  endtask

  task automatic rand_inputs();
    logic [6:0] low;
    case ($urandom_range(0, 3))
      0:       low = 7'h0B;
      1:       low = 7'h2B;
      2:       low = 7'h13;
      default: low = 7'($urandom());
    endcase
    dq_v     = 1'($urandom_range(0, 1));
    dq.id    = IdT'($urandom_range(0, SbLen - 1));
    dq.instr = ($urandom() & 32'hFFFF_FF80) | {25'd0, low};
    eq_v     = 1'($urandom_range(0, 1));
    eq       = ExeReqT'({$urandom(), $urandom(), $urandom(), $urandom()});
    ds_r     = ($urandom_range(0, 9) < 7);
    es_r     = ($urandom_range(0, 9) < 7);
    m_dq_r   = 2'($urandom());
    m_eq_r   = 2'($urandom());
    m_ds_v   = 2'($urandom());
    m_es_v   = 2'($urandom());
    for (int i = 0; i < 2; i++) begin
      m_ds[i] = DecRspW'($urandom());
      m_es[i] = ExeRspW'({$urandom(), $urandom()});
    end
  endtask

  // Called just after a falling edge with inputs set: check, then advance model at the rising edge.
  task automatic step();
    int dt, et, dg, eg, fid;
    bit dfree, dhs, ehs, wdr, wer;
    logic [1:0] wv;
    logic [2:0] req, wp;
    DecRspT dexp;
    ExeRspT eexp;
    #2;
    dt    = route(dq.instr);
    dfree = !sb_busy[dq.id];
    wdr   = dfree && ((dt == Loc) ? (ldq.size() == 0) : m_dq_r[dt]);
    check_eq("dec_req_ready", dq_r, wdr);
    wv = '0;
    if (dq_v && dfree && dt != Loc) wv[dt] = 1'b1;
    check_eq("mst_dec_req_valid", m_dq_v, wv);
    if (wv != 0) check_eq("mst_dec_req_data", m_dq[dt], dq);
    dhs = dq_v && wdr;

    et  = (dhs && dq.id == eq.id) ? dt : (sb_busy[eq.id] ? sb_who[eq.id] : Loc);
    wer = (et == Loc) ? (leq.size() == 0) : m_eq_r[et];
    check_eq("exe_req_ready", eq_r, wer);
    wv = '0;
    if (eq_v && et != Loc) wv[et] = 1'b1;
    check_eq("mst_exe_req_valid", m_eq_v, wv);
    if (wv != 0) check_eq("mst_exe_req_data", m_eq[et], eq);
    ehs = eq_v && wer;

    req = {ldq.size() > 0, m_ds_v};
    dg  = pick(req, dptr, dlock, dlk);
    check_eq("dec_rsp_valid", ds_v, dg >= 0);
    dexp = '0;
    if (dg == Loc) dexp.id = IdT'(ldq[0]);
    else if (dg >= 0) dexp = DecRspT'(m_ds[dg]);
    if (dg >= 0) check_eq("dec_rsp_data", ds, dexp);
    wv = '0;
    if (dg >= 0 && dg != Loc && ds_r) wv[dg] = 1'b1;
    check_eq("mst_dec_rsp_ready", m_ds_r, wv);

    req = {leq.size() > 0, m_es_v};
    eg  = pick(req, eptr, elock, elk);
    check_eq("exe_rsp_valid", es_v, eg >= 0);
    eexp = '0;
    if (eg == Loc) eexp.id = IdT'(leq[0]);
    else if (eg >= 0) eexp = ExeRspT'(m_es[eg]);
    if (eg >= 0) check_eq("exe_rsp_data", es, eexp);
    wv = '0;
    if (eg >= 0 && eg != Loc && es_r) wv[eg] = 1'b1;
    check_eq("mst_exe_rsp_ready", m_es_r, wv);

    wp = '0;
    for (int i = 0; i < SbLen; i++) if (sb_busy[i]) wp[sb_who[i]] = 1'b1;
    check_eq("pending", pend, wp);

    @(posedge clk);
    if (dg >= 0 && ds_r) begin
      dlock = 1'b0;
      dptr  = (dg + 1) % 3;
      if (dg == Loc) begin
        fid = ldq.pop_front();
        if (sb_busy[fid] && sb_who[fid] == Loc) sb_busy[fid] = 1'b0;
      end
    end else if (dg >= 0) begin
      dlock = 1'b1;
      dlk   = dg;
    end
    if (eg >= 0 && es_r) begin
      elock = 1'b0;
      eptr  = (eg + 1) % 3;
      sb_busy[eexp.id] = 1'b0;
      if (eg == Loc) fid = leq.pop_front();
    end else if (eg >= 0) begin
      elock = 1'b1;
      elk   = eg;
    end
    if (dhs) begin
      sb_busy[dq.id] = 1'b1;
      sb_who[dq.id]  = dt;
      if (dt == Loc) ldq.push_back(int'(dq.id));
    end
    if (ehs && et == Loc) leq.push_back(int'(eq.id));
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {dq_r, eq_r, ds_v, es_v, m_dq_v, m_eq_v, m_ds_r, m_es_r, pend}, '0);
  endtask

  initial begin
    model_reset();
    idle();
    dq_v = 1'b1; eq_v = 1'b1; ds_r = 1'b1; es_r = 1'b1; m_ds_v = 2'b11; m_es_v = 2'b11;
    #12 check_quiet("reset_outputs");
    @(negedge clk);
    rstn = 1'b1;
    idle();

    // Matched decode to mst[0], execute, then result frees the entry.
    dq_v = 1'b1; dq.id = 3'd3; dq.instr = 32'h0000_000B;
    step();
    idle();
    #1 check_eq("pend_after_dec3", pend, 3'b001);
    eq_v = 1'b1; eq.id = 3'd3;
    step();
    idle();
    xr = '0; xr.id = 3'd3; m_es_v = 2'b01; m_es[0] = xr; es_r = 1'b1;
    step();
    idle();
    #1 check_eq("pend_after_rsp3", pend, 3'b000);

    // Unmatched decode goes to the local responder.
    dq_v = 1'b1; dq.id = 3'd1; dq.instr = 32'h0000_0013;
    step();
    idle();
    dr = '0; dr.id = 3'd1;
    #1 check_eq("loc_dec_rsp", {ds_v, ds}, {1'b1, dr});
    ds_r = 1'b1;
    step();
    idle();
    eq_v = 1'b1; eq.id = 3'd1;
    step();
    idle();
    xr = '0; xr.id = 3'd1;
    #1 check_eq("loc_exe_rsp", {es_v, es}, {1'b1, xr});
    es_r = 1'b1;
    step();
    idle();

    // Busy entry stalls the decode until its execute response is taken.
    dq_v = 1'b1; dq.id = 3'd5; dq.instr = 32'h0000_000B;
    step();
    #1 check_eq("busy_stall", dq_r, 1'b0);
    xr = '0; xr.id = 3'd5; m_es_v = 2'b01; m_es[0] = xr; es_r = 1'b1;
    step();
    m_es_v = 2'b00; es_r = 1'b0;
    #1 check_eq("busy_release", dq_r, 1'b1);
    step();
    idle();
    m_es_v = 2'b01; m_es[0] = xr; es_r = 1'b1;
    step();
    idle();

    // Round robin between two always-valid masters; idle LOC is skipped.
    ds_r = 1'b1; m_ds_v = 2'b11;
    dr = '0; dr.id = 3'd1; m_ds[0] = dr;
    dr.id = 3'd2; m_ds[1] = dr;
    for (int k = 0; k < 4; k++) begin
      #1 check_eq("rr_grant", ds.id, (k % 2 == 0) ? 3'd1 : 3'd2);
      step();
    end

    // Stalled grant to mst[1] stays put while mst[0] also requests.
    ds_r = 1'b0; m_ds_v = 2'b10;
    step();
    m_ds_v = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("lock_hold", ds.id, 3'd2);
      step();
    end
    ds_r = 1'b1;
    #1 check_eq("lock_release", ds.id, 3'd2);
    step();
    idle();

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset in the middle of traffic.
    rand_inputs();
    dq_v = 1'b1; eq_v = 1'b1; ds_r = 1'b1; es_r = 1'b1; m_ds_v = 2'b11; m_es_v = 2'b11;
    #3 rstn = 1'b0;
    #1 check_quiet("mid_reset");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
